tb_mem_model: RTL and testbench

Parametrised dual-port memory model for the core's simulation bench: one instruction port and one data port sharing a single word-addressed array. Grant throttling, response latency, the outstanding-request limit and out-of-range error reporting are all configurable, so the core's fetch and LSU handshakes can be exercised under stall and latency. It sits beside `riscv_core` in `tb`. The array is named `mem` so that `$readmemh` preload works unchanged.

---
 rtl/tb_mem_pkg.sv | 22 ++
 rtl/tb_mem_resp_pipe.sv | 58 +++++
 rtl/tb_mem_model.sv | 113 +++++++++++
 tb/tb_tb_mem_model.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_mem_pkg.sv
// Shared types and helpers for the tb_mem_model simulation memory.
package tb_mem_pkg;

   localparam int TB_MEM_MAX_LAT = 8;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } tb_mem_resp_t;

   function automatic logic [31:0] be_merge(input logic [31:0] old,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/tb_mem_resp_pipe.sv
// Per-port grant throttle and fixed-latency response pipe.
module tb_mem_resp_pipe
   import tb_mem_pkg::*;
#(
   parameter int LATENCY         = 1,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STALL_EVERY     = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req,
   input  tb_mem_resp_t resp_in,
   output logic         gnt,
   output tb_mem_resp_t resp_out
);

   tb_mem_resp_t pipe [LATENCY];
   logic [3:0]   outstanding;
   logic [31:0]  stall_cnt;
   logic         stall;

   assign stall = (STALL_EVERY > 0) && req && (stall_cnt == 32'(STALL_EVERY - 1));

   // Grant ignores a same-cycle retirement so it never depends on the valid path.
   assign gnt = req && !stall && !reset && (outstanding < 4'(MAX_OUTSTANDING));

   assign resp_out = pipe[LATENCY-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (req) begin
         stall_cnt <= stall ? '0 : stall_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
      end else begin
         unique case ({gnt, resp_out.valid})
            2'b10:   outstanding <= outstanding + 4'd1;
            2'b01:   outstanding <= outstanding - 4'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= gnt ? resp_in : '0;
         for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

endmodule

// File: rtl/tb_mem_model.sv
// Dual-port (instr/data) word-addressed memory model with throttled grants and fixed response latency.
module tb_mem_model
   import tb_mem_pkg::*;
#(
   parameter int MEM_WORDS       = 65536,
   parameter int I_LATENCY       = 1,
   parameter int D_LATENCY       = 1,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STALL_EVERY     = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_req,
   input  logic [31:0] instr_addr,
   output logic        instr_gnt,
   output logic [31:0] instr_rdata,
   output logic        instr_valid,
   output logic        instr_err,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_byteen,
   output logic        data_gnt,
   output logic [31:0] data_rdata,
   output logic        data_valid,
   output logic        data_error
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   if (I_LATENCY < 1 || I_LATENCY > TB_MEM_MAX_LAT) begin : g_bad_i_latency
      $fatal(1, "tb_mem_model: I_LATENCY must be 1..8");
   end
   if (D_LATENCY < 1 || D_LATENCY > TB_MEM_MAX_LAT) begin : g_bad_d_latency
      $fatal(1, "tb_mem_model: D_LATENCY must be 1..8");
   end
   if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_max_out
      $fatal(1, "tb_mem_model: MAX_OUTSTANDING must be 1..8");
   end

   logic [31:0]  mem [MEM_WORDS];

   logic [29:0]  i_index;
   logic [29:0]  d_index;
   logic         i_oor;
   logic         d_oor;
   logic         addr_lsb_unused;
   tb_mem_resp_t i_resp;
   tb_mem_resp_t d_resp;
   tb_mem_resp_t i_out;
   tb_mem_resp_t d_out;

   assign i_index         = instr_addr[31:2];
   assign d_index         = data_addr[31:2];
   assign i_oor           = {2'b00, i_index} >= 32'(MEM_WORDS);
   assign d_oor           = {2'b00, d_index} >= 32'(MEM_WORDS);
   assign addr_lsb_unused = ^{instr_addr[1:0], data_addr[1:0]};

   // Reads sample the array before this edge's store lands, giving read-before-write on collisions.
   always_comb begin
      i_resp       = '0;
      i_resp.valid = 1'b1;
      if (i_oor) i_resp.err   = 1'b1;
      else       i_resp.rdata = mem[i_index[AW-1:0]];

      d_resp       = '0;
      d_resp.valid = 1'b1;
      if (d_oor)         d_resp.err   = 1'b1;
      else if (!data_wr) d_resp.rdata = mem[d_index[AW-1:0]];
   end

   // No reset on the array: contents survive reset, and granted stores are never undone.
   always_ff @(posedge clk) begin
      if (data_gnt && data_wr && !d_oor) begin
         mem[d_index[AW-1:0]] <= be_merge(mem[d_index[AW-1:0]], data_wdata, data_byteen);
      end
   end

   tb_mem_resp_pipe #(
      .LATENCY         (I_LATENCY),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .STALL_EVERY     (STALL_EVERY)
   ) u_instr_pipe (
      .clk      (clk),
      .reset    (reset),
      .req      (instr_req),
      .resp_in  (i_resp),
      .gnt      (instr_gnt),
      .resp_out (i_out)
   );

   tb_mem_resp_pipe #(
      .LATENCY         (D_LATENCY),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .STALL_EVERY     (STALL_EVERY)
   ) u_data_pipe (
      .clk      (clk),
      .reset    (reset),
      .req      (data_req),
      .resp_in  (d_resp),
      .gnt      (data_gnt),
      .resp_out (d_out)
   );

   assign instr_valid = i_out.valid;
   assign instr_err   = i_out.err;
   assign instr_rdata = i_out.rdata;
   assign data_valid  = d_out.valid;
   assign data_error  = d_out.err;
   assign data_rdata  = d_out.rdata;

endmodule

// File: tb/tb_tb_mem_model.sv
// Bench for tb_mem_model: queue-based response model on the main instance, literal checks for stalls.
module tb_tb_mem_model;

   localparam int WORDS   = 64;
   localparam int AW      = 6;
   localparam int I_LAT   = 3;
   localparam int D_LAT   = 4;
   localparam int MAX_OUT = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_req = 1'b0;
   logic [31:0] instr_addr = '0;
   logic        instr_gnt;
   logic [31:0] instr_rdata;
   logic        instr_valid;
   logic        instr_err;
   logic        data_req = 1'b0;
   logic        data_wr = 1'b0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic [3:0]  data_byteen = '0;
   logic        data_gnt;
   logic [31:0] data_rdata;
   logic        data_valid;
   logic        data_error;

   logic        s_instr_req = 1'b0;
   logic [31:0] s_instr_addr = '0;
   logic        s_instr_gnt;
   logic [31:0] s_instr_rdata;
   logic        s_instr_valid;
   logic        s_instr_err;
   logic        s_data_req = 1'b0;
   logic        s_data_wr = 1'b0;
   logic [31:0] s_data_addr = '0;
   logic [31:0] s_data_wdata = '0;
   logic [3:0]  s_data_byteen = '0;
   logic        s_data_gnt;
   logic [31:0] s_data_rdata;
   logic        s_data_valid;
   logic        s_data_error;

   int n_cmp = 0;
   int n_bad = 0;

   tb_mem_model #(
      .MEM_WORDS(WORDS), .I_LATENCY(I_LAT), .D_LATENCY(D_LAT),
      .MAX_OUTSTANDING(MAX_OUT), .STALL_EVERY(0)
   ) u_dut (
      .clk(clk), .reset(reset),
      .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
      .instr_rdata(instr_rdata), .instr_valid(instr_valid), .instr_err(instr_err),
      .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_byteen(data_byteen), .data_gnt(data_gnt),
      .data_rdata(data_rdata), .data_valid(data_valid), .data_error(data_error)
   );

   tb_mem_model #(
      .MEM_WORDS(WORDS), .I_LATENCY(1), .D_LATENCY(1),
      .MAX_OUTSTANDING(2), .STALL_EVERY(3)
   ) u_stall (
      .clk(clk), .reset(reset),
      .instr_req(s_instr_req), .instr_addr(s_instr_addr), .instr_gnt(s_instr_gnt),
      .instr_rdata(s_instr_rdata), .instr_valid(s_instr_valid), .instr_err(s_instr_err),
      .data_req(s_data_req), .data_wr(s_data_wr), .data_addr(s_data_addr),
      .data_wdata(s_data_wdata), .data_byteen(s_data_byteen), .data_gnt(s_data_gnt),
      .data_rdata(s_data_rdata), .data_valid(s_data_valid), .data_error(s_data_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: expected responses queued with the cycle they are due.
   typedef struct {
      int          due;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        iq[$];
   exp_t        dq[$];
   logic [31:0] mm [WORDS];
   int          cyc = 0;
   int          i_out = 0;
   int          d_out = 0;

   always @(negedge clk) begin
      bit          ir, dr, igr, dgr, ioor, door;
      logic [31:0] iidx, didx;
      exp_t        e;
      if (reset) begin
         iq.delete();
         dq.delete();
         i_out = 0;
         d_out = 0;
         chk("rst_instr_gnt", 32'(instr_gnt), 32'd0);
         chk("rst_data_gnt", 32'(data_gnt), 32'd0);
         chk("rst_instr_valid", 32'(instr_valid), 32'd0);
         chk("rst_data_valid", 32'(data_valid), 32'd0);
         chk("rst_instr_err", 32'(instr_err), 32'd0);
         chk("rst_data_error", 32'(data_error), 32'd0);
         chk("rst_instr_rdata", instr_rdata, 32'd0);
         chk("rst_data_rdata", data_rdata, 32'd0);
      end else begin
         ir = (iq.size() > 0) && (iq[0].due == cyc);
         chk("model_instr_valid", 32'(instr_valid), 32'(ir));
         if (ir) begin
            chk("model_instr_err", 32'(instr_err), 32'(iq[0].err));
            chk("model_instr_rdata", instr_rdata, iq[0].rdata);
            void'(iq.pop_front());
         end
         dr = (dq.size() > 0) && (dq[0].due == cyc);
         chk("model_data_valid", 32'(data_valid), 32'(dr));
         if (dr) begin
            chk("model_data_error", 32'(data_error), 32'(dq[0].err));
            chk("model_data_rdata", data_rdata, dq[0].rdata);
            void'(dq.pop_front());
         end

         igr = instr_req && (i_out < MAX_OUT);
         dgr = data_req && (d_out < MAX_OUT);
         chk("model_instr_gnt", 32'(instr_gnt), 32'(igr));
         chk("model_data_gnt", 32'(data_gnt), 32'(dgr));

         iidx = instr_addr >> 2;
         didx = data_addr >> 2;
         ioor = iidx >= WORDS;
         door = didx >= WORDS;
         if (igr) begin
            e.due   = cyc + I_LAT;
            e.err   = ioor;
            e.rdata = ioor ? 32'd0 : mm[iidx[AW-1:0]];
            iq.push_back(e);
            i_out++;
         end
         if (dgr) begin
            e.due   = cyc + D_LAT;
            e.err   = door;
            e.rdata = (door || data_wr) ? 32'd0 : mm[didx[AW-1:0]];
            dq.push_back(e);
            d_out++;
            if (data_wr && !door) begin
               for (int b = 0; b < 4; b++) begin
                  if (data_byteen[b]) mm[didx[AW-1:0]][8*b +: 8] = data_wdata[8*b +: 8];
               end
            end
         end
         if (ir) i_out--;
         if (dr) d_out--;
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      instr_req = 1'b0;
      data_req  = 1'b0;
      repeat (12) step();
   endtask

   task automatic data_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
      bit got = 1'b0;
      data_req    = 1'b1;
      data_wr     = wr;
      data_addr   = addr;
      data_wdata  = wdata;
      data_byteen = be;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         got = data_gnt;
         step();
      end
      data_req = 1'b0;
      if (!got) chk("data_gnt_wait", 32'(got), 32'd1);
   endtask

   task automatic wait_dvalid(output logic [31:0] rd, output logic er);
      bit seen = 1'b0;
      rd = '0;
      er = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (data_valid) begin
            seen = 1'b1;
            rd   = data_rdata;
            er   = data_error;
         end
      end
      chk("data_valid_wait", 32'(seen), 32'd1);
      step();
   endtask

   task automatic wait_ivalid(output logic [31:0] rd, output logic er);
      bit seen = 1'b0;
      rd = '0;
      er = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (instr_valid) begin
            seen = 1'b1;
            rd   = instr_rdata;
            er   = instr_err;
         end
      end
      chk("instr_valid_wait", 32'(seen), 32'd1);
      step();
   endtask

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 9);
      if (r == 0) return $urandom;
      if (r == 1) return 32'(WORDS * 4) + 32'($urandom_range(0, 63) * 4);
      return 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(0, 3));
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [8:0]  spat;
      logic [5:0]  opat;
      int          vsum;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Stall throttling on the second instance.
      s_instr_req = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         spat[8-k] = s_instr_gnt;
         step();
      end
      s_instr_req = 1'b0;
      chk("stall_grant_pattern", 32'(spat), 32'(9'b110110110));

      for (int w = 0; w < WORDS; w++) begin
         logic [31:0] v;
         v = $urandom;
         if (w == 0) v = 32'h0000_0013;
         if (w == 4) v = 32'h1122_3344;
         if (w == 5) v = 32'h0000_0001;
         data_op(1'b1, 32'(w * 4), v, 4'hF);
      end
      drain();

      // Instruction read latency.
      instr_req  = 1'b1;
      instr_addr = 32'h0;
      @(negedge clk);
      chk("ifetch_gnt", 32'(instr_gnt), 32'd1);
      step();
      instr_req = 1'b0;
      @(negedge clk);
      chk("ifetch_valid_t1", 32'(instr_valid), 32'd0);
      @(negedge clk);
      chk("ifetch_valid_t2", 32'(instr_valid), 32'd0);
      @(negedge clk);
      chk("ifetch_valid_t3", 32'(instr_valid), 32'd1);
      chk("ifetch_rdata", instr_rdata, 32'h0000_0013);
      chk("ifetch_err", 32'(instr_err), 32'd0);
      drain();

      // Byte-enable merge.
      data_op(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101);
      drain();
      data_op(1'b0, 32'h10, 32'h0, 4'h0);
      wait_dvalid(rd, er);
      chk("be_merge_rdata", rd, 32'h11BB_33DD);
      chk("be_merge_err", 32'(er), 32'd0);
      drain();

      // Outstanding limit.
      data_req  = 1'b1;
      data_wr   = 1'b0;
      data_addr = 32'h20;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         opat[5-k] = data_gnt;
         step();
      end
      data_req = 1'b0;
      chk("outstanding_pattern", 32'(opat), 32'(6'b110001));
      drain();

      // Out-of-range load and store.
      data_op(1'b0, 32'(WORDS * 4), 32'h0, 4'h0);
      wait_dvalid(rd, er);
      chk("oor_load_err", 32'(er), 32'd1);
      chk("oor_load_rdata", rd, 32'd0);
      drain();
      data_op(1'b1, 32'(WORDS * 4), 32'hDEAD_BEEF, 4'hF);
      wait_dvalid(rd, er);
      chk("oor_store_err", 32'(er), 32'd1);
      drain();
      data_op(1'b0, 32'h0, 32'h0, 4'h0);
      wait_dvalid(rd, er);
      chk("oor_store_no_alias", rd, 32'h0000_0013);
      drain();

      // Same-cycle instr read / data store collision.
      instr_req   = 1'b1;
      instr_addr  = 32'h14;
      data_req    = 1'b1;
      data_wr     = 1'b1;
      data_addr   = 32'h14;
      data_wdata  = 32'h2;
      data_byteen = 4'hF;
      @(negedge clk);
      chk("collide_instr_gnt", 32'(instr_gnt), 32'd1);
      chk("collide_data_gnt", 32'(data_gnt), 32'd1);
      step();
      instr_req = 1'b0;
      data_req  = 1'b0;
      wait_ivalid(rd, er);
      chk("collide_old_data", rd, 32'h0000_0001);
      drain();

      // Reset with a read in flight.
      instr_req  = 1'b1;
      instr_addr = 32'h14;
      @(negedge clk);
      chk("inflight_gnt", 32'(instr_gnt), 32'd1);
      step();
      instr_req = 1'b0;
      reset     = 1'b1;
      vsum      = 0;
      for (int k = 0; k < 8; k++) begin
         if (k == 2) reset = 1'b0;
         @(negedge clk);
         vsum += int'(instr_valid);
         step();
      end
      chk("reset_discards_inflight", 32'(vsum), 32'd0);
      data_op(1'b0, 32'h14, 32'h0, 4'h0);
      wait_dvalid(rd, er);
      chk("store_survives_reset", rd, 32'h0000_0002);
      drain();

      // Randomized traffic against the model, with one reset pulse.
      for (int k = 0; k < 600; k++) begin
         instr_req   = ($urandom_range(0, 3) != 0);
         instr_addr  = rand_addr();
         data_req    = ($urandom_range(0, 3) != 0);
         data_wr     = 1'($urandom_range(0, 1));
         data_addr   = rand_addr();
         data_wdata  = $urandom;
         data_byteen = 4'($urandom_range(0, 15));
         reset       = (k == 300) || (k == 301);
         step();
      end
      reset = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
